// File: rtl/branch_resolve_queue_pkg.sv
// Shared branch-tracking types: queue depth, tag width, entry layout.
// Imported by the branch resolve queue and its users.
package sys_defs;

  localparam int BRQ_DEPTH = 8;
  localparam int BRQ_TAG_W = $clog2(BRQ_DEPTH);

  typedef struct packed {
    logic        valid;
    logic        resolved;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } BRQ_ENTRY;

endpackage

// File: rtl/brq_mispredict_check.sv
// Compares a fetch-time prediction against the executed outcome.
// In: entry pc/prediction, ex_taken/ex_target. Out: mispredict, redirect_pc.
module brq_mispredict_check (
  input  logic [31:0] pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  logic dir_bad;
  logic tgt_bad;

  assign dir_bad = pred_taken != ex_taken;
  assign tgt_bad = pred_taken & ex_taken
                 & (pred_target != ex_target);

  assign mispredict  = dir_bad | tgt_bad;
  assign redirect_pc = ex_taken ? ex_target
                                : pc + 32'd4;

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks fetched branches to resolution; drives BTB update and redirect.
// Ports: clock/reset/enable, fetch alloc (if_*, alloc_tag, full, count),
// execute resolve (ex_*), registered BTB update (btb_*), mispredict and
// redirect_pc. BRQ_DEBUG_OUT_EN adds valid_out, resolved_out, pc_out,
// head_out and tail_out mirroring the internal state.
module branch_resolve_queue #(
  parameter  int BRQ_DEPTH = sys_defs::BRQ_DEPTH,
  localparam int TW        = $clog2(BRQ_DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          if_alloc,
  input  logic [31:0]   if_pc,
  input  logic          if_pred_taken,
  input  logic [31:0]   if_pred_target,
  output logic [TW-1:0] alloc_tag,
  output logic          full,
  output logic [TW:0]   count,
  input  logic          ex_resolve,
  input  logic [TW-1:0] ex_tag,
  input  logic          ex_taken,
  input  logic [31:0]   ex_target,
  output logic [31:0]   btb_ex_pc,
  output logic [31:0]   btb_calculated_pc,
  output logic          btb_branch_taken,
  output logic          btb_en_branch,
  output logic          mispredict,
  output logic [31:0]   redirect_pc
`ifdef BRQ_DEBUG_OUT_EN
  ,
  output logic [BRQ_DEPTH-1:0] valid_out,
  output logic [BRQ_DEPTH-1:0] resolved_out,
  output logic [31:0]          pc_out [BRQ_DEPTH],
  output logic [TW-1:0]        head_out,
  output logic [TW-1:0]        tail_out
`endif
);

  import sys_defs::*;

  BRQ_ENTRY [BRQ_DEPTH-1:0] ent;
  BRQ_ENTRY                 rent;

  logic [TW-1:0]        head;
  logic [TW-1:0]        tail;
  logic [TW-1:0]        off_tag;
  logic [BRQ_DEPTH-1:0] young;
  logic                 legal;
  logic                 mp;
  logic                 flush;
  logic                 retire;
  logic                 alloc;
  logic [31:0]          rd_pc;

  assign rent    = ent[ex_tag];
  assign legal   = enable & ex_resolve
                 & rent.valid & ~rent.resolved;
  assign flush   = legal & mp;
  assign retire  = enable & ent[head].valid
                 & ent[head].resolved;
  assign full    = count == (TW+1)'(BRQ_DEPTH);
  assign alloc   = enable & if_alloc & ~full & ~flush;
  assign alloc_tag = tail;
  assign off_tag = ex_tag - head;

  // Age is distance from head, so wrap-around needs no special case.
  always_comb begin
    young = '0;
    for (int i = 0; i < BRQ_DEPTH; i++)
      young[i] = (TW'(i) - head) > off_tag;
  end

  brq_mispredict_check u_chk (
    .pc          (rent.pc),
    .pred_taken  (rent.pred_taken),
    .pred_target (rent.pred_target),
    .ex_taken    (ex_taken),
    .ex_target   (ex_target),
    .mispredict  (mp),
    .redirect_pc (rd_pc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent <= '0;
    end else begin
      if (legal)
        ent[ex_tag].resolved <= 1'b1;
      if (retire) begin
        ent[head].valid    <= 1'b0;
        ent[head].resolved <= 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < BRQ_DEPTH; i++) begin
          if (young[i]) begin
            ent[i].valid    <= 1'b0;
            ent[i].resolved <= 1'b0;
          end
        end
      end
      if (alloc) begin
        ent[tail].valid       <= 1'b1;
        ent[tail].resolved    <= 1'b0;
        ent[tail].pc          <= if_pc;
        ent[tail].pred_taken  <= if_pred_taken;
        ent[tail].pred_target <= if_pred_target;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      btb_ex_pc         <= '0;
      btb_calculated_pc <= '0;
      btb_branch_taken  <= 1'b0;
      btb_en_branch     <= 1'b0;
      mispredict        <= 1'b0;
      redirect_pc       <= '0;
    end else begin
      if (retire)
        head <= head + TW'(1);
      if (flush)
        tail <= ex_tag + TW'(1);
      else if (alloc)
        tail <= tail + TW'(1);
      // The flushed queue spans head..ex_tag inclusive.
      if (flush)
        count <= (TW+1)'(off_tag) + (TW+1)'(1)
               - (TW+1)'(retire);
      else
        count <= count + (TW+1)'(alloc)
               - (TW+1)'(retire);
      btb_en_branch <= legal;
      mispredict    <= flush;
      if (legal) begin
        btb_ex_pc         <= rent.pc;
        btb_calculated_pc <= ex_target;
        btb_branch_taken  <= ex_taken;
      end
      if (flush)
        redirect_pc <= rd_pc;
    end
  end

`ifdef BRQ_DEBUG_OUT_EN
  always_comb begin
    for (int i = 0; i < BRQ_DEPTH; i++) begin
      valid_out[i]    = ent[i].valid;
      resolved_out[i] = ent[i].resolved;
      pc_out[i]       = ent[i].pc;
    end
  end
  assign head_out = head;
  assign tail_out = tail;
`else
  // State mirrors compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Random + directed bench for branch_resolve_queue against an
// in-order queue model of outstanding branches.
module tb_branch_resolve_queue;

  localparam int D = 8;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        if_alloc;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic [2:0]  alloc_tag;
  logic        full;
  logic [3:0]  count;
  logic        ex_resolve;
  logic [2:0]  ex_tag;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] btb_ex_pc;
  logic [31:0] btb_calculated_pc;
  logic        btb_branch_taken;
  logic        btb_en_branch;
  logic        mispredict;
  logic [31:0] redirect_pc;

  branch_resolve_queue #(.BRQ_DEPTH(D)) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .if_alloc          (if_alloc),
    .if_pc             (if_pc),
    .if_pred_taken     (if_pred_taken),
    .if_pred_target    (if_pred_target),
    .alloc_tag         (alloc_tag),
    .full              (full),
    .count             (count),
    .ex_resolve        (ex_resolve),
    .ex_tag            (ex_tag),
    .ex_taken          (ex_taken),
    .ex_target         (ex_target),
    .btb_ex_pc         (btb_ex_pc),
    .btb_calculated_pc (btb_calculated_pc),
    .btb_branch_taken  (btb_branch_taken),
    .btb_en_branch     (btb_en_branch),
    .mispredict        (mispredict),
    .redirect_pc       (redirect_pc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: outstanding branches in program order, oldest first.
  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        res;
  } ment_t;

  ment_t       q[$];
  int          next_tag;
  logic [31:0] e_pc;
  logic [31:0] e_cpc;
  logic        e_tk;
  logic [31:0] e_rd;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    enable = 0; if_alloc = 0; if_pc = 0;
    if_pred_taken = 0; if_pred_target = 0;
    ex_resolve = 0; ex_tag = 0; ex_taken = 0; ex_target = 0;
  endtask

  task automatic model_clear();
    q.delete();
    next_tag = 0;
    e_pc = 0; e_cpc = 0; e_tk = 0; e_rd = 0;
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_count"}, count, 0);
    chk({t, "_full"}, full, 0);
    chk({t, "_tag"}, alloc_tag, 0);
    chk({t, "_btb_en"}, btb_en_branch, 0);
    chk({t, "_btb_pc"}, btb_ex_pc, 0);
    chk({t, "_btb_cpc"}, btb_calculated_pc, 0);
    chk({t, "_btb_tk"}, btb_branch_taken, 0);
    chk({t, "_mispred"}, mispredict, 0);
    chk({t, "_redir"}, redirect_pc, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1;
    @(posedge clock);
    #1;
    chk_zero("reset");
    model_clear();
    @(negedge clock);
    reset = 0;
  endtask

  task automatic step(input logic en, input logic al,
                      input logic [31:0] pc, input logic pt,
                      input logic [31:0] ptg, input logic rs,
                      input int tg, input logic tk,
                      input logic [31:0] tt);
    int   idx;
    logic legal, mp, ret, alc;
    @(negedge clock);
    enable = en; if_alloc = al; if_pc = pc;
    if_pred_taken = pt; if_pred_target = ptg;
    ex_resolve = rs; ex_tag = tg[2:0];
    ex_taken = tk; ex_target = tt;
    #1;
    chk("alloc_tag", alloc_tag, next_tag);
    chk("count", count, q.size());
    chk("full", full, q.size() == D);
    idx = -1;
    foreach (q[i]) if (q[i].tag == tg) idx = i;
    legal = en && rs && idx >= 0 && !q[idx].res;
    mp = 0;
    if (legal) begin
      mp = (q[idx].pt != tk)
        || (q[idx].pt && tk && q[idx].ptgt != tt);
      e_pc = q[idx].pc; e_cpc = tt; e_tk = tk;
      if (mp) e_rd = tk ? tt : q[idx].pc + 32'd4;
    end
    ret = en && q.size() > 0 && q[0].res;
    alc = en && al && q.size() < D && !(legal && mp);
    if (legal) q[idx].res = 1;
    if (legal && mp) begin
      while (q.size() > idx + 1) void'(q.pop_back());
      next_tag = (tg + 1) % D;
    end
    if (ret) void'(q.pop_front());
    if (alc) begin
      q.push_back('{next_tag, pc, pt, ptg, 1'b0});
      next_tag = (next_tag + 1) % D;
    end
    @(posedge clock);
    #1;
    chk("btb_en", btb_en_branch, legal);
    chk("mispredict", mispredict, legal && mp);
    chk("btb_ex_pc", btb_ex_pc, e_pc);
    chk("btb_cpc", btb_calculated_pc, e_cpc);
    chk("btb_tk", btb_branch_taken, e_tk);
    if (legal && mp) chk("redirect", redirect_pc, e_rd);
  endtask

  task automatic alloc1(input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptg);
    step(1, 1, pc, pt, ptg, 0, 0, 0, 0);
  endtask

  task automatic res1(input int tg, input logic tk,
                      input logic [31:0] tt);
    step(1, 0, 0, 0, 0, 1, tg, tk, tt);
  endtask

  task automatic idle1();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int          k, tg;
    logic        en, al, pt, rs, tk;
    logic [31:0] pc, ptg, tt;
    n_chk = 0; n_pass = 0;
    idle_inputs();
    model_clear();
    reset = 1;
    do_reset();

    // Reset then one allocation.
    alloc1(32'h100, 0, 0);
    chk("tp1_count", count, 1);

    // Correct taken prediction, then retirement.
    do_reset();
    alloc1(32'h200, 1, 32'h300);
    res1(0, 1, 32'h300);
    chk("tp2_btb_pc", btb_ex_pc, 32'h200);
    chk("tp2_cpc", btb_calculated_pc, 32'h300);
    chk("tp2_mp", mispredict, 0);
    idle1();
    chk("tp2_retired", count, 0);

    // Direction mispredict with flush of younger entries.
    do_reset();
    for (int i = 0; i < 4; i++) alloc1(32'(i * 'h40), 1, 32'h1000);
    res1(1, 0, 32'h0);
    chk("tp3_mp", mispredict, 1);
    chk("tp3_redir", redirect_pc, 32'h44);
    chk("tp3_count", count, 2);
    chk("tp3_tag", alloc_tag, 2);
    idle1();

    // Target mispredict.
    do_reset();
    alloc1(32'h80, 1, 32'h500);
    res1(0, 1, 32'h600);
    chk("tp4_mp", mispredict, 1);
    chk("tp4_redir", redirect_pc, 32'h600);
    chk("tp4_tk", btb_branch_taken, 1);

    // Full, dropped allocation, wrap-around.
    do_reset();
    for (int i = 0; i < D; i++) alloc1(32'(i * 4), 0, 0);
    chk("tp5_full", full, 1);
    alloc1(32'h999, 0, 0);
    chk("tp5_drop", count, 8);
    res1(0, 0, 0);
    idle1();
    chk("tp5_notfull", full, 0);
    alloc1(32'h777, 0, 0);
    chk("tp5_refill", count, 8);

    // Illegal resolves.
    do_reset();
    alloc1(32'h10, 0, 0);
    alloc1(32'h20, 0, 0);
    res1(5, 1, 32'h55);
    chk("tp6_inval", btb_en_branch, 0);
    res1(0, 0, 0);
    res1(0, 1, 32'h77);
    chk("tp6_twice_en", btb_en_branch, 0);
    chk("tp6_twice_mp", mispredict, 0);

    // Randomised traffic with one asynchronous reset mid-run.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en  = $urandom_range(0, 99) < 92;
      al  = $urandom_range(0, 99) < 60;
      pc  = $urandom & ~32'h3;
      pt  = 1'($urandom_range(0, 1));
      ptg = $urandom & ~32'h3;
      rs  = $urandom_range(0, 99) < 50;
      k = -1;
      if (q.size() > 0 && $urandom_range(0, 9) < 8)
        k = $urandom_range(0, q.size() - 1);
      tg = (k >= 0) ? q[k].tag : $urandom_range(0, D - 1);
      tk = 1'($urandom_range(0, 1));
      tt = $urandom & ~32'h3;
      if (k >= 0 && $urandom_range(0, 9) < 7) begin
        tk = q[k].pt;
        if (tk) tt = q[k].ptgt;
      end else if (k >= 0 && $urandom_range(0, 1) == 1) begin
        tt = q[k].ptgt;
      end
      step(en, al, pc, pt, ptg, rs, tg, tk, tt);
      if (c == 1500) begin
        #2;
        idle_inputs();
        reset = 1;
        #1;
        chk_zero("async_rst");
        model_clear();
        @(negedge clock);
        reset = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
